// File: rtl/prt_riscv_dpram.sv
// prt_riscv_dpram: dual-port RISC-V memory, read-only fetch port A, byte-strobed data port B,
// pipelined read latency and a streaming init loader that owns the array while busy.
module prt_riscv_dpram #(
  parameter int    P_ADR       = 10,
  parameter int    P_LAT       = 2,
  parameter string P_INIT_FILE = "none"
) (
  input  logic             CLK_IN,
  input  logic             RST_IN,
  input  logic             INIT_STR_IN,
  input  logic             INIT_STP_IN,
  input  logic [31:0]      INIT_DAT_IN,
  input  logic             INIT_VLD_IN,
  output logic             INIT_BUSY_OUT,
  output logic             INIT_OVF_OUT,
  input  logic             A_RD_IN,
  input  logic [P_ADR-1:0] A_ADR_IN,
  output logic             A_RDY_OUT,
  output logic [31:0]      A_DAT_OUT,
  output logic             A_VLD_OUT,
  input  logic             B_RD_IN,
  input  logic             B_WR_IN,
  input  logic [P_ADR-1:0] B_ADR_IN,
  input  logic [31:0]      B_WR_DAT_IN,
  input  logic [3:0]       B_WR_STRB_IN,
  output logic             B_RDY_OUT,
  output logic [31:0]      B_DAT_OUT,
  output logic             B_VLD_OUT
);
  localparam int W = P_ADR - 2;
  localparam int D = 2 ** W;
  typedef enum logic {IDLE, LOAD} state_t;
  state_t state_q, state_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic ovf_q, ovf_d, rdy_q, rdy_d, init_we, b_wr;
  logic [1:0] acc;
  logic [W-1:0] idx [2];
  logic [31:0] mem [D];
  logic [1:0][P_LAT-1:0] v_q, v_d;
  logic [1:0][P_LAT-1:0][31:0] p_q, p_d;
  logic unused_adr;

  generate
    if (P_LAT < 1 || P_LAT > 3) begin : g_bad_lat
      $error("prt_riscv_dpram: P_LAT must be 1..3");
    end
  endgenerate

  assign unused_adr = ^{A_ADR_IN[1:0], B_ADR_IN[1:0]};

  always_comb begin
    state_d = INIT_STR_IN ? LOAD : INIT_STP_IN ? IDLE : state_q;
    init_we = state_q == LOAD && INIT_VLD_IN && !INIT_STR_IN;
    ptr_d   = INIT_STR_IN ? '0 : init_we ? ptr_q + 1'b1 : ptr_q;
    ovf_d   = !INIT_STR_IN && (ovf_q || (init_we && &ptr_q));
    rdy_d   = state_d == IDLE;
    idx[0]  = A_ADR_IN[P_ADR-1:2];
    idx[1]  = B_ADR_IN[P_ADR-1:2];
    b_wr    = B_WR_IN && rdy_q;
    acc     = {B_RD_IN && !B_WR_IN && rdy_q, A_RD_IN && rdy_q};
    for (int p = 0; p < 2; p++) begin
      v_d[p][0] = acc[p];
      p_d[p][0] = acc[p] ? mem[idx[p]] : p_q[p][0];
      for (int k = 1; k < P_LAT; k++) begin
        v_d[p][k] = v_q[p][k-1];
        p_d[p][k] = v_q[p][k-1] ? p_q[p][k-1] : p_q[p][k];
      end
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (init_we) mem[ptr_q] <= INIT_DAT_IN;
    else if (b_wr)
      for (int i = 0; i < 4; i++)
        if (B_WR_STRB_IN[i]) mem[idx[1]][8*i +: 8] <= B_WR_DAT_IN[8*i +: 8];
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
      rdy_q   <= 1'b0;
      v_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
      rdy_q   <= rdy_d;
      v_q     <= v_d;
      p_q     <= p_d;
    end
  end

  assign INIT_BUSY_OUT = state_q == LOAD;
  assign INIT_OVF_OUT  = ovf_q;
  assign A_RDY_OUT     = rdy_q;
  assign B_RDY_OUT     = rdy_q;
  assign A_VLD_OUT     = v_q[0][P_LAT-1];
  assign A_DAT_OUT     = p_q[0][P_LAT-1];
  assign B_VLD_OUT     = v_q[1][P_LAT-1];
  assign B_DAT_OUT     = p_q[1][P_LAT-1];
endmodule

// File: tb/tb_prt_riscv_dpram.sv
// tb_prt_riscv_dpram: directed checks on three latency variants plus a 4-word loader variant.
module tb_prt_riscv_dpram;
  logic clk, rst;
  logic init_str, init_stp, init_vld;
  logic [31:0] init_dat;
  logic a_rd, b_rd, b_wr;
  logic [9:0] a_adr, b_adr;
  logic [31:0] b_wdat;
  logic [3:0] b_strb;
  logic [2:0] busy, ovf, a_rdy, a_vld, b_rdy, b_vld;
  logic [31:0] a_dat [3];
  logic [31:0] b_dat [3];
  logic s_busy, s_ovf, s_a_rdy, s_a_vld, s_b_rdy, s_b_vld;
  logic [31:0] s_a_dat, s_b_dat;
  int n_err = 0, n_chk = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    prt_riscv_dpram #(.P_ADR(10), .P_LAT(g + 1)) u_dut (
      .CLK_IN(clk), .RST_IN(rst),
      .INIT_STR_IN(init_str), .INIT_STP_IN(init_stp), .INIT_DAT_IN(init_dat), .INIT_VLD_IN(init_vld),
      .INIT_BUSY_OUT(busy[g]), .INIT_OVF_OUT(ovf[g]),
      .A_RD_IN(a_rd), .A_ADR_IN(a_adr), .A_RDY_OUT(a_rdy[g]), .A_DAT_OUT(a_dat[g]), .A_VLD_OUT(a_vld[g]),
      .B_RD_IN(b_rd), .B_WR_IN(b_wr), .B_ADR_IN(b_adr), .B_WR_DAT_IN(b_wdat), .B_WR_STRB_IN(b_strb),
      .B_RDY_OUT(b_rdy[g]), .B_DAT_OUT(b_dat[g]), .B_VLD_OUT(b_vld[g]));
  end

  prt_riscv_dpram #(.P_ADR(4), .P_LAT(2)) u_small (
    .CLK_IN(clk), .RST_IN(rst),
    .INIT_STR_IN(init_str), .INIT_STP_IN(init_stp), .INIT_DAT_IN(init_dat), .INIT_VLD_IN(init_vld),
    .INIT_BUSY_OUT(s_busy), .INIT_OVF_OUT(s_ovf),
    .A_RD_IN(a_rd), .A_ADR_IN(a_adr[3:0]), .A_RDY_OUT(s_a_rdy), .A_DAT_OUT(s_a_dat), .A_VLD_OUT(s_a_vld),
    .B_RD_IN(b_rd), .B_WR_IN(b_wr), .B_ADR_IN(b_adr[3:0]), .B_WR_DAT_IN(b_wdat), .B_WR_STRB_IN(b_strb),
    .B_RDY_OUT(s_b_rdy), .B_DAT_OUT(s_b_dat), .B_VLD_OUT(s_b_vld));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic b_write(input logic [9:0] adr, input logic [31:0] dat, input logic [3:0] strb);
    b_wr = 1'b1; b_adr = adr; b_wdat = dat; b_strb = strb;
    tick();
    b_wr = 1'b0;
  endtask

  task automatic read_a(input logic [9:0] adr, input logic [31:0] exp, input bit s_en, input logic [31:0] s_exp);
    a_rd = 1'b1; a_adr = adr;
    tick();
    a_rd = 1'b0;
    chk("a_vld_l1", a_vld, 3'b001);
    chk("a_dat_l1", a_dat[0], exp);
    tick();
    chk("a_vld_l2", a_vld, 3'b010);
    chk("a_dat_l2", a_dat[1], exp);
    if (s_en) chk("s_a_dat", {s_a_vld, s_a_dat[30:0]}, {1'b1, s_exp[30:0]});
    tick();
    chk("a_vld_l3", a_vld, 3'b100);
    chk("a_dat_l3", a_dat[2], exp);
    tick();
  endtask

  task automatic read_b(input logic [9:0] adr, input logic [31:0] exp);
    b_rd = 1'b1; b_adr = adr;
    tick();
    b_rd = 1'b0;
    chk("b_vld_l1", b_vld, 3'b001);
    chk("b_dat_l1", b_dat[0], exp);
    tick();
    chk("b_dat_l2", b_dat[1], exp);
    tick();
    chk("b_dat_l3", b_dat[2], exp);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    {init_str, init_stp, init_vld, a_rd, b_rd, b_wr} = '0;
    init_dat = '0; a_adr = '0; b_adr = '0; b_wdat = '0; b_strb = '0;
    repeat (2) tick();
    chk("rst_busy", {s_busy, busy}, 4'h0);
    chk("rst_ovf", {s_ovf, ovf}, 4'h0);
    chk("rst_vld", {s_a_vld, s_b_vld, a_vld, b_vld}, 8'h00);
    chk("rst_dat", a_dat[1] | b_dat[1], 32'h0);
    rst = 1'b0;
    tick();
    chk("rst_rdy", {s_a_rdy, s_b_rdy, a_rdy, b_rdy}, 8'hFF);
    // basic write then read on every latency
    b_write(10'h10, 32'h11223344, 4'hF);
    read_a(10'h10, 32'h11223344, 1'b0, 32'h0);
    // byte strobes and read-after-write on port B
    b_write(10'h14, 32'hAABBCCDD, 4'hF);
    b_write(10'h14, 32'h00000099, 4'h1);
    read_b(10'h14, 32'hAABBCC99);
    b_write(10'h14, 32'h12345678, 4'h0);
    read_b(10'h14, 32'hAABBCC99);
    // A/B collision is read-first
    b_write(10'h20, 32'h1, 4'hF);
    a_rd = 1'b1; a_adr = 10'h20; b_wr = 1'b1; b_adr = 10'h20; b_wdat = 32'h2; b_strb = 4'hF;
    tick();
    b_wr = 1'b0;
    chk("col_l1_old", a_dat[0], 32'h1);
    tick();
    a_rd = 1'b0;
    chk("col_l1_new", a_dat[0], 32'h2);
    chk("col_l2_old", a_dat[1], 32'h1);
    tick();
    chk("col_l2_new", a_dat[1], 32'h2);
    repeat (2) tick();
    // simultaneous B read+write: write wins, no read data
    b_rd = 1'b1; b_wr = 1'b1; b_adr = 10'h28; b_wdat = 32'h77; b_strb = 4'hF;
    tick();
    b_rd = 1'b0; b_wr = 1'b0;
    for (int t = 0; t < 3; t++) begin
      chk("rdwr_novld", b_vld, 3'b000);
      tick();
    end
    read_b(10'h28, 32'h77);
    // init loader with wrap on the 4-word instance
    init_str = 1'b1;
    tick();
    init_str = 1'b0;
    chk("ld_busy", {s_busy, busy}, 4'hF);
    chk("ld_rdy", {s_a_rdy, s_b_rdy, a_rdy, b_rdy}, 8'h00);
    for (int i = 0; i < 5; i++) begin
      init_vld = 1'b1; init_dat = i;
      tick();
    end
    init_vld = 1'b0;
    chk("ld_ovf", {s_ovf, ovf}, 4'b1000);
    chk("ld_rdy_hold", s_a_rdy, 1'b0);
    init_stp = 1'b1;
    tick();
    init_stp = 1'b0;
    chk("stp_busy", {s_busy, busy}, 4'h0);
    chk("stp_rdy", {s_a_rdy, s_b_rdy, a_rdy, b_rdy}, 8'hFF);
    chk("stp_ovf_sticky", s_ovf, 1'b1);
    init_vld = 1'b1; init_dat = 32'hDEAD;
    tick();
    init_vld = 1'b0;
    read_a(10'h0, 32'h0, 1'b1, 32'h4);
    read_a(10'h4, 32'h1, 1'b1, 32'h1);
    read_a(10'h8, 32'h2, 1'b1, 32'h2);
    read_a(10'hC, 32'h3, 1'b1, 32'h3);
    read_a(10'h10, 32'h4, 1'b0, 32'h0);
    read_a(10'h14, 32'hAABBCC99, 1'b0, 32'h0);
    // reset in the middle of a load
    init_str = 1'b1;
    tick();
    init_str = 1'b0;
    init_vld = 1'b1; init_dat = 32'hA0;
    tick();
    init_dat = 32'hA1;
    tick();
    init_vld = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {s_busy, busy}, 4'h0);
    chk("mid_rst_vld", {s_a_vld, a_vld, b_vld}, 7'h0);
    chk("mid_rst_ovf", s_ovf, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_rdy", {s_a_rdy, s_b_rdy, a_rdy, b_rdy}, 8'hFF);
    chk("mid_rst_idle", {s_busy, busy}, 4'h0);
    read_a(10'h0, 32'hA0, 1'b1, 32'hA0);
    read_a(10'h4, 32'hA1, 1'b1, 32'hA1);
    // eight back-to-back reads across all latencies
    for (int i = 0; i < 8; i++) b_write(10'h40 + 10'(4 * i), 32'hC0DE0000 + i, 4'hF);
    for (int t = 0; t < 11; t++) begin
      a_rd = t < 8; a_adr = 10'h40 + 10'(4 * t);
      tick();
      for (int g = 0; g < 3; g++) begin
        chk("b2b_vld", a_vld[g], (t - g >= 0 && t - g < 8) ? 1'b1 : 1'b0);
        if (t - g >= 0 && t - g < 8) chk("b2b_dat", a_dat[g], 32'hC0DE0000 + (t - g));
      end
    end
    a_rd = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
